// File: rtl/sample_feeder_pkg.sv
// sample_feeder_pkg
//   Shared types and constants for the sample_feeder block.
//   - state_t      : feeder FSM state encoding
//   - UNDERRUN_W   : width of the saturating underrun counter
//   - UNDERRUN_MAX : saturation value of the underrun counter
package sample_feeder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PRIME  = 2'd1,
    ST_STREAM = 2'd2
  } state_t;

  localparam int UNDERRUN_W = 16;
  localparam logic [UNDERRUN_W-1:0] UNDERRUN_MAX = '1;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
//   Single-clock FIFO with registered read data (1-cycle read latency) and
//   no fall-through: a word written in cycle N can first be popped in N+1.
//   Ports:
//     i_clk, i_reset  : clock, synchronous active-high reset
//     i_push, i_wr_data : write strobe and data (ignored when full or clearing)
//     i_pop           : read strobe (ignored when empty or clearing)
//     i_clear         : synchronous flush of pointers and level
//     o_level         : occupancy, 0..2^DEPTH_LOG2
//     o_rd_data       : word read by the most recent pop
module sync_fifo #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_push,
  input  logic [WIDTH-1:0]      i_wr_data,
  input  logic                  i_pop,
  input  logic                  i_clear,
  output logic [DEPTH_LOG2:0]   o_level,
  output logic [WIDTH-1:0]      o_rd_data
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LVL_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_level;
  logic [WIDTH-1:0]      r_rd_data;

  logic w_push;
  logic w_pop;

  assign w_push = i_push && !i_clear && (r_level != LVL_FULL);
  assign w_pop  = i_pop  && !i_clear && (r_level != '0);

  // Storage has no reset; pointers and level define what is valid.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  // Pointers wrap naturally at 2^DEPTH_LOG2.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rd_data <= '0;
    end else if (w_pop) begin
      r_rd_data <= r_mem[r_rd_ptr];
    end
  end

  assign o_level   = r_level;
  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/sample_feeder.sv
// sample_feeder
//   Fabric-side transmitter for the HPS sampler port. Buffers producer words
//   in a FIFO and, once the sampler is active and the FIFO is primed, emits
//   one word per clock. Empty cycles while streaming emit FILL_WORD and bump
//   a saturating underrun counter.
//   Ports:
//     i_clk, i_reset     : clock, synchronous active-high reset
//     i_in_data/valid    : producer word and valid
//     o_in_ready         : word accepted this cycle (independent of pops)
//     i_sampler_active   : high while the HPS is sampling
//     o_sample_data      : word to the sampler (1-cycle latency from pop)
//     o_sample_is_fill   : o_sample_data is FILL_WORD
//     o_underrun_count   : saturating underrun cycle count
//     o_level            : FIFO occupancy
//
//   state   | meaning
//   --------+-------------------------------------------------------
//   IDLE    | sampler inactive; buffer words, output fill
//   PRIME   | sampler active; wait for PRIME_LEVEL words, output fill
//   STREAM  | one pop per cycle; empty cycles are underruns
module sample_feeder
  import sample_feeder_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter int               DEPTH_LOG2  = 4,
  parameter int               PRIME_LEVEL = 4,
  parameter logic [WIDTH-1:0] FILL_WORD   = '0
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic [WIDTH-1:0]       i_in_data,
  input  logic                   i_in_valid,
  output logic                   o_in_ready,
  input  logic                   i_sampler_active,
  output logic [WIDTH-1:0]       o_sample_data,
  output logic                   o_sample_is_fill,
  output logic [UNDERRUN_W-1:0]  o_underrun_count,
  output logic [DEPTH_LOG2:0]    o_level
);

  localparam logic [DEPTH_LOG2:0] LVL_FULL  = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] LVL_PRIME = PRIME_LEVEL[DEPTH_LOG2:0];

  state_t r_state;
  state_t w_state_nxt;

  logic                  w_flush;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_underrun;
  logic                  w_in_ready;
  logic [DEPTH_LOG2:0]   w_level;
  logic [WIDTH-1:0]      w_rd_data;

  logic                  r_is_fill;
  logic [UNDERRUN_W-1:0] r_underrun;

  sync_fifo #(
    .WIDTH      (WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_push    (w_push),
    .i_wr_data (i_in_data),
    .i_pop     (w_pop),
    .i_clear   (w_flush),
    .o_level   (w_level),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_sampler_active) w_state_nxt = ST_PRIME;
      end
      ST_PRIME: begin
        if (!i_sampler_active)       w_state_nxt = ST_IDLE;
        else if (w_level >= LVL_PRIME) w_state_nxt = ST_STREAM;
      end
      ST_STREAM: begin
        if (!i_sampler_active) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Ready looks only at registered level and the flush condition, never at
  // a same-cycle pop, so it has no combinational path through the FSM pop.
  always_comb begin
    w_flush    = (r_state != ST_IDLE) && !i_sampler_active;
    w_in_ready = (w_level != LVL_FULL) && !w_flush;
    w_push     = i_in_valid && w_in_ready;
    w_pop      = 1'b0;
    w_underrun = 1'b0;
    if (r_state == ST_STREAM && i_sampler_active) begin
      w_pop      = (w_level != '0);
      w_underrun = (w_level == '0);
    end
  end

  // The FIFO read register already holds the popped word after the edge, so
  // only the fill flag is registered here and steers the output mux.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_is_fill <= 1'b1;
    end else begin
      r_is_fill <= !w_pop;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_underrun <= '0;
    end else if (w_underrun && (r_underrun != UNDERRUN_MAX)) begin
      r_underrun <= r_underrun + 1'b1;
    end
  end

  assign o_in_ready       = w_in_ready;
  assign o_sample_data    = r_is_fill ? FILL_WORD : w_rd_data;
  assign o_sample_is_fill = r_is_fill;
  assign o_underrun_count = r_underrun;
  assign o_level          = w_level;

endmodule

// File: tb/tb_sample_feeder.sv
module tb_sample_feeder;

  localparam logic [31:0] FILL = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        active;
  logic [31:0] sample_data;
  logic        is_fill;
  logic [15:0] underrun;
  logic [4:0]  level;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sample_feeder #(
    .WIDTH       (32),
    .DEPTH_LOG2  (4),
    .PRIME_LEVEL (4),
    .FILL_WORD   (FILL)
  ) dut (
    .i_clk            (clk),
    .i_reset          (reset),
    .i_in_data        (in_data),
    .i_in_valid       (in_valid),
    .o_in_ready       (in_ready),
    .i_sampler_active (active),
    .o_sample_data    (sample_data),
    .o_sample_is_fill (is_fill),
    .o_underrun_count (underrun),
    .o_level          (level)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] d);
    in_data  = d;
    in_valid = 1'b1;
    #1;
    check_val("push_rdy", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] next_push;
    logic [31:0] exp_pop;
    reset    = 1'b1;
    in_data  = '0;
    in_valid = 1'b0;
    active   = 1'b0;
    tick(); tick(); tick();
    reset = 1'b0;
    tick();

    // Reset state
    check_val("rst_fill",  32'(is_fill), 32'd1);
    check_val("rst_data",  sample_data, FILL);
    check_val("rst_level", 32'(level), 32'd0);
    check_val("rst_under", 32'(underrun), 32'd0);
    check_val("rst_rdy",   32'(in_ready), 32'd1);

    // Buffer four words while the sampler is idle
    for (int k = 0; k < 4; k++) push_word(32'h11 + 32'(k));
    check_val("t1_level", 32'(level), 32'd4);
    check_val("t1_fill",  32'(is_fill), 32'd1);

    // Primed start: first word visible three cycles after active rises
    active = 1'b1;
    tick();
    check_val("t2_prime_fill", 32'(is_fill), 32'd1);
    tick();
    check_val("t2_first_fill", 32'(is_fill), 32'd1);
    tick();
    for (int k = 0; k < 4; k++) begin
      check_val("t2_data", sample_data, 32'h11 + 32'(k));
      check_val("t2_real", 32'(is_fill), 32'd0);
      tick();
    end
    check_val("t2_end_fill", 32'(is_fill), 32'd1);
    check_val("t2_end_data", sample_data, FILL);
    check_val("t2_under",    32'(underrun), 32'd1);
    active = 1'b0;
    #1;
    check_val("t2_flush_rdy", 32'(in_ready), 32'd0);
    tick();
    check_val("t2_idle_under", 32'(underrun), 32'd1);

    // Flush with level 7 from PRIME
    for (int k = 0; k < 7; k++) push_word(32'h31 + 32'(k));
    check_val("t5_level7", 32'(level), 32'd7);
    active = 1'b1;
    tick();
    active   = 1'b0;
    in_valid = 1'b1;
    in_data  = 32'h99;
    #1;
    check_val("t5_flush_rdy", 32'(in_ready), 32'd0);
    check_val("t5_flush_lvl", 32'(level), 32'd7);
    tick();
    in_valid = 1'b0;
    check_val("t5_level0", 32'(level), 32'd0);
    check_val("t5_fill",   32'(is_fill), 32'd1);
    check_val("t5_data",   sample_data, FILL);
    check_val("t5_under",  32'(underrun), 32'd1);
    #1;
    check_val("t5_rdy", 32'(in_ready), 32'd1);

    // Partial prime: no streaming until PRIME_LEVEL reached
    reset_pulse();
    check_val("t3_under_rst", 32'(underrun), 32'd0);
    push_word(32'h21);
    push_word(32'h22);
    active = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check_val("t3_wait_fill",  32'(is_fill), 32'd1);
      check_val("t3_wait_under", 32'(underrun), 32'd0);
      check_val("t3_wait_level", 32'(level), 32'd2);
    end
    push_word(32'h23);
    push_word(32'h24);
    check_val("t3_lvl4_fill", 32'(is_fill), 32'd1);
    tick();
    check_val("t3_trans_fill", 32'(is_fill), 32'd1);
    tick();
    for (int k = 0; k < 4; k++) begin
      check_val("t3_data", sample_data, 32'h21 + 32'(k));
      check_val("t3_real", 32'(is_fill), 32'd0);
      tick();
    end
    active = 1'b0;
    tick();

    // Full FIFO, then steady push+pop streaming
    reset_pulse();
    for (int k = 0; k < 16; k++) push_word(32'h100 + 32'(k));
    in_data  = 32'h110;
    in_valid = 1'b1;
    #1;
    check_val("t4_full_rdy", 32'(in_ready), 32'd0);
    check_val("t4_full_lvl", 32'(level), 32'd16);
    tick(); tick();
    check_val("t4_full_hold", 32'(level), 32'd16);
    next_push = 32'h110;
    exp_pop   = 32'h100;
    active    = 1'b1;
    for (int c = 0; c < 40; c++) begin
      logic acc;
      in_data = next_push;
      #1;
      acc = in_ready;
      if (!is_fill) begin
        check_val("t4_seq", sample_data, exp_pop);
        exp_pop = exp_pop + 1;
      end
      if (c >= 3) begin
        check_val("t4_level", 32'(level), 32'd15);
        check_val("t4_nofill", 32'(is_fill), 32'd0);
      end
      tick();
      if (acc) next_push = next_push + 1;
    end
    check_val("t4_npops", exp_pop, 32'h125);
    // Reset mid-stream discards buffered data
    reset = 1'b1;
    tick();
    check_val("t4_rst_level", 32'(level), 32'd0);
    check_val("t4_rst_fill",  32'(is_fill), 32'd1);
    reset    = 1'b0;
    in_valid = 1'b0;
    active   = 1'b0;
    tick();

    // Underrun saturation and reset recovery
    for (int k = 0; k < 4; k++) push_word(32'h41 + 32'(k));
    active = 1'b1;
    for (int k = 0; k < 70000; k++) tick();
    check_val("t6_sat",  32'(underrun), 32'hFFFF);
    check_val("t6_fill", 32'(is_fill), 32'd1);
    reset = 1'b1;
    tick();
    check_val("t6_rst_under", 32'(underrun), 32'd0);
    check_val("t6_rst_data",  sample_data, FILL);
    check_val("t6_rst_fill",  32'(is_fill), 32'd1);
    check_val("t6_rst_level", 32'(level), 32'd0);
    active = 1'b0;
    reset  = 1'b0;
    tick();
    check_val("t6_rdy", 32'(in_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sample_feeder.md
# sample_feeder

Fabric-side transmitter for the HPS sampler port. It accepts words from a fabric producer over a valid/ready handshake and buffers them in a small FIFO. Once the sampler is active, it presents exactly one word per clock on the sampler's data input. When no data is available it inserts a fill word and counts the underrun. It sits between user logic and the `sample_export` connection of `hps_system`, replacing the direct `player`-to-`sampler` loopback.

## Interface
- `WIDTH`, 32: sample word width; must match the sampler width configured in Qsys.
- `DEPTH_LOG2`, 4: FIFO depth is 2^DEPTH_LOG2 words.
- `PRIME_LEVEL`, 4: minimum FIFO level required before streaming starts; range 1..2^DEPTH_LOG2.
- `FILL_WORD`, 0: value driven when no valid data is presented.
- `clk`  in  1  system clock (50 MHz board oscillator).
- `reset`  in  1  synchronous, active-high reset.
- `in_data`  in  WIDTH  producer word.
- `in_valid`  in  1  producer word valid.
- `in_ready`  out  1  feeder accepts the word this cycle.
- `sampler_active`  in  1  the sampler's `sample_reset_reset_n` output; high while the HPS is sampling.
- `sample_data`  out  WIDTH  word to the sampler, registered.
- `sample_is_fill`  out  1  `sample_data` holds `FILL_WORD` rather than producer data, registered.
- `underrun_count`  out  16  saturating count of underrun cycles.
- `level`  out  DEPTH_LOG2+1  current FIFO occupancy, 0..2^DEPTH_LOG2.

## Operation
- A push occurs when `in_valid && in_ready`.
- `in_ready` = (level != 2^DEPTH_LOG2) && !flush. `flush` is true when state != IDLE && !sampler_active.
- `in_ready` never depends on a same-cycle pop.
- The FIFO has no fall-through: a word pushed in cycle N can first be popped in cycle N+1.
- States:
  - IDLE: no pops; `sample_data`=FILL_WORD, `sample_is_fill`=1; pushes accepted. Go to PRIME when `sampler_active`=1.
  - PRIME: no pops; fill output; fill cycles here are not underruns. Go to STREAM when level ≥ PRIME_LEVEL. Go to IDLE with flush when `sampler_active`=0.
  - STREAM: every cycle, pop one word if level>0 and drive it out with `sample_is_fill`=0. If level==0, drive FILL_WORD with `sample_is_fill`=1 and increment `underrun_count`. Go to IDLE with flush when `sampler_active`=0.
- Flush cycle:
  - FIFO pointers and level are cleared.
  - No push occurs (`in_ready` is 0) and no pop occurs.
  - Output is a fill word; this is not an underrun.
- A push and a pop in the same cycle leave level unchanged. Pointers wrap modulo 2^DEPTH_LOG2.
- `underrun_count` saturates at 16'hFFFF. It is cleared only by reset, not by a flush.
- Reset:
  - state=IDLE, level=0, pointers=0.
  - `sample_data`=FILL_WORD, `sample_is_fill`=1, `underrun_count`=0.
  - `in_ready` is 1 one cycle after reset deasserts.
  - Reset asserted mid-stream discards all buffered data.

## Timing
- A pop decision in cycle N appears on `sample_data` at the edge ending cycle N (visible during cycle N+1). Latency is 1 clock.
- Rising `sampler_active` sampled in cycle N puts the state in PRIME for cycle N+1.
- Streaming cannot begin before cycle N+2:
  - The first popped word is visible at N+3 when the FIFO is already primed.
  - Otherwise it is visible one cycle after the level reaches PRIME_LEVEL plus one (PRIME→STREAM transition).
- `level` and `underrun_count` are registered and update on the same edge as `sample_data`.
- `sampler_active` is synchronous to `clk`; no synchroniser is needed.

## Structure
- `sample_feeder_pkg` holds the state enum (IDLE, PRIME, STREAM) and the underrun counter width constant (16).
- Sub-module `sync_fifo` (parameters WIDTH, DEPTH_LOG2; ports push/pop/clear/level/rd_data; synchronous read, 1-cycle latency).
- The FSM, fill mux and counter stay in `sample_feeder`.

## Test plan
- Reset, then push 4 words 0x11..0x14 with `sampler_active`=0 → `in_ready`=1 throughout, level=4, output stays fill.
- Raise `sampler_active` with level=4 → 0x11..0x14 on `sample_data` on consecutive cycles, `sample_is_fill`=0. The fifth cycle is fill with `underrun_count`=1.
- PRIME_LEVEL=4, push 2 words, then raise `sampler_active` and hold for 10 cycles → no pops, `underrun_count`=0. Push 2 more → streaming starts and emits all 4 in order.
- Fill the FIFO to 16 with `sampler_active`=0 → `in_ready`=0 and further `in_valid` is ignored. In STREAM with continuous push and pop, level holds steady and there is no data loss or duplication (sequence check).
- Drop `sampler_active` with level=7 → `in_ready`=0 for one cycle, then level=0 and output fill. `underrun_count` is retained.
- Force 70000 underrun cycles → `underrun_count` holds at 0xFFFF. Asserting `reset` returns it to 0 and returns all outputs to their reset values.
